// File: rtl/key_input_conditioner.sv
// Pushbutton conditioner: synchronises and debounces the active-low KEY inputs, then
// produces a clean level, one-cycle press/release pulses, sticky press events and an irq.
module key_input_conditioner #(
    parameter int NUM_KEYS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_event,
    input  logic [NUM_KEYS-1:0] event_clear,
    output logic                irq
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } deb_state_t;

    genvar i;
    generate
        for (i = 0; i < NUM_KEYS; i++) begin : g_key
            logic [SYNC_STAGES-1:0] sync_r;
            logic                   sample_s;
            deb_state_t             state_r;
            deb_state_t             state_s;
            logic [CNT_W-1:0]       cnt_r;
            logic [CNT_W-1:0]       cnt_s;
            logic                   level_r;
            logic                   level_s;
            logic                   press_r;
            logic                   press_s;
            logic                   release_r;
            logic                   release_s;
            logic                   event_r;
            logic                   event_s;

            // Synchroniser chain on the inverted key, so 1 means pressed.
            always_ff @(posedge CLOCK_50 or negedge reset_n) begin
                if (!reset_n) begin
                    sync_r <= '0;
                end else begin
                    sync_r <= {sync_r[SYNC_STAGES-2:0], ~KEY[i]};
                end
            end

            assign sample_s = sync_r[SYNC_STAGES-1];

            // Debounce next-state, pulse generation and event capture.
            always_comb begin
                state_s   = state_r;
                cnt_s     = cnt_r;
                level_s   = level_r;
                press_s   = 1'b0;
                release_s = 1'b0;
                case (state_r)
                    STABLE: begin
                        if (sample_s != level_r) begin
                            state_s = COUNTING;
                            cnt_s   = CNT_ONE;
                        end else begin
                            cnt_s   = CNT_ZERO;
                        end
                    end
                    COUNTING: begin
                        if (sample_s == level_r) begin
                            state_s = STABLE;
                            cnt_s   = CNT_ZERO;
                        end else if (cnt_r == CNT_MAX) begin
                            state_s   = STABLE;
                            cnt_s     = CNT_ZERO;
                            level_s   = ~level_r;
                            press_s   = ~level_r;
                            release_s = level_r;
                        end else begin
                            cnt_s   = cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        state_s = STABLE;
                        cnt_s   = CNT_ZERO;
                    end
                endcase
                // A completing press beats a coincident clear.
                if (press_s) begin
                    event_s = 1'b1;
                end else if (event_clear[i]) begin
                    event_s = 1'b0;
                end else begin
                    event_s = event_r;
                end
            end

            // Debounce state, counter and registered outputs.
            always_ff @(posedge CLOCK_50 or negedge reset_n) begin
                if (!reset_n) begin
                    state_r   <= STABLE;
                    cnt_r     <= CNT_ZERO;
                    level_r   <= 1'b0;
                    press_r   <= 1'b0;
                    release_r <= 1'b0;
                    event_r   <= 1'b0;
                end else begin
                    state_r   <= state_s;
                    cnt_r     <= cnt_s;
                    level_r   <= level_s;
                    press_r   <= press_s;
                    release_r <= release_s;
                    event_r   <= event_s;
                end
            end

            assign key_level[i]   = level_r;
            assign key_press[i]   = press_r;
            assign key_release[i] = release_r;
            assign key_event[i]   = event_r;
        end
    endgenerate

    assign irq = |key_event;

endmodule

// File: doc/key_input_conditioner.md
# key_input_conditioner

Input-side counterpart to the hex display path: conditions the raw DE2 pushbuttons before they reach the Nios `keys_export` PIO. Per key, it synchronises the raw active-low `KEY` input into `CLOCK_50`, debounces it with a counter, and produces three things: a clean level, one-cycle press/release pulses, and sticky event bits. Software clears the event bits with a per-bit clear strobe, and `irq` requests service while any event is pending. The block sits in the top level between `KEY` and the Nios system.

## Interface
Parameters:
- `NUM_KEYS`, 4: number of pushbuttons conditioned.
- `SYNC_STAGES`, 2: synchroniser flops per key; legal values are 2 or more.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles needed to accept a change. 500000 cycles is 10 ms at 50 MHz. Legal values are 2 or more; the counter width is clog2(`DEBOUNCE_CYCLES`).

Ports:
- `CLOCK_50`, in, 1: the single clock; all state is on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `KEY`, in, `NUM_KEYS`: raw pushbuttons, asynchronous, low when pressed.
- `key_level`, out, `NUM_KEYS`: debounced state, 1 = pressed.
- `key_press`, out, `NUM_KEYS`: one-cycle pulse on a debounced press.
- `key_release`, out, `NUM_KEYS`: one-cycle pulse on a debounced release.
- `key_event`, out, `NUM_KEYS`: sticky press-capture bits.
- `event_clear`, in, `NUM_KEYS`: per-bit clear strobe for `key_event`, sampled every cycle.
- `irq`, out, 1: OR of `key_event`.

## Operation
Each key is handled independently; there is no interaction between keys except through `irq`.
- **Synchroniser:** a `SYNC_STAGES`-deep flop chain on `~KEY[i]`. The last stage is the sample `s[i]`, with 1 = pressed.
- **Debounce states:** two states per key, STABLE and COUNTING, with counter `cnt[i]`.
  - STABLE (`s == key_level`): `cnt` is held at 0.
  - When `s != key_level`, the key enters COUNTING and `cnt` increments each cycle that `s` still differs.
  - If `s` returns to equal `key_level` before expiry, `cnt` goes to 0 and the key returns to STABLE. A glitch shorter than `DEBOUNCE_CYCLES` produces no output activity.
  - On the cycle `cnt == DEBOUNCE_CYCLES-1` with `s` still differing, `key_level` toggles, `cnt` goes to 0 and the key returns to STABLE.
- **Pulses:**
  - `key_press[i]` is registered high for exactly the cycle in which `key_level[i]` first reads 1.
  - `key_release[i]` is registered high for exactly the cycle in which `key_level[i]` first reads 0 after having been 1.
  - Press and release can never be high together on the same key.
- **Event capture:** at each edge `key_event[i]` is updated as follows.
  - It is set if the key is toggling to pressed at that edge, so it rises in the same cycle as `key_press`.
  - Otherwise it is cleared if `event_clear[i]` is 1.
  - Otherwise it holds.
  - If a set and a clear coincide, the set wins.
  - A clear applied to a bit that is already 0 has no effect.
  - Repeated presses while the bit is already set are not counted; the bit simply stays 1.
- **`irq`:** combinational OR of the `key_event` register bits; it does not depend on `event_clear` in the same cycle.
- **Reset:**
  - All synchroniser flops reset to 0 (released).
  - `cnt`, `key_level`, `key_press`, `key_release` and `key_event` reset to 0, so `irq` is 0.
  - Asserting `reset_n` mid-count abandons the count; no pulse or event is produced.
  - A key held through reset release is treated as a new press and is reported after the full latency.

## Timing
- **Press/release latency:** `KEY` changes and meets setup before edge E0. `key_level`, `key_press`/`key_release` and `key_event` change after edge E0 + (`SYNC_STAGES` - 1) + `DEBOUNCE_CYCLES`. With the defaults this is `SYNC_STAGES` + `DEBOUNCE_CYCLES` - 1 = 500001 cycles after the first sampling edge.
- **Pulse width:** exactly 1 cycle per debounced transition.
- **Clear latency:** `event_clear[i]` sampled high at edge E makes `key_event[i]` and `irq` low from E onward, unless a set occurs at that edge.
- **Throughput:** a minimum of `DEBOUNCE_CYCLES` cycles between accepted transitions on one key.
- **Multiple keys:** any number of keys may toggle on the same edge; every pulse and event bit updates independently.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES`=8 and `SYNC_STAGES`=2.
- **Reset values:** hold `reset_n`=0 with `KEY`=4'b0000 (all pressed). All outputs are 0 during reset. After release, `key_level`=4'hF, `key_press`=4'hF for one cycle and `key_event`=4'hF exactly 9 cycles after the first sampling edge.
- **Clean press and release:** drive `KEY[0]`=0 steady. `key_level[0]` rises and `key_press[0]`, `key_event[0]` and `irq` go high after edge E0+9; `key_press[0]` lasts 1 cycle. Then drive `KEY[0]`=1. `key_release[0]` pulses 9 cycles later and `key_event[0]` stays 1.
- **Bounce rejection:** toggle `KEY[1]` with low runs of 7 cycles and high runs of 3 cycles, repeated 5 times, then leave it high. `key_level[1]`, `key_press[1]` and `key_event[1]` all stay 0.
- **Clear vs set collision:**
  - With `key_event[2]`=1, assert `event_clear[2]` on the same edge that a new debounced press completes on key 2. The result is `key_event[2]`=1 and `irq`=1.
  - Then assert `event_clear[2]` alone for one cycle. The result is `key_event[2]`=0, and `irq`=0 when no other bits are set.
- **Reset mid-count:** press `KEY[3]` and pulse `reset_n` low at count 5. No `key_press[3]` occurs before reset release. `key_press[3]` occurs 9 cycles after the first post-reset sampling edge.
- **Simultaneous keys:** press `KEY[0]` and `KEY[3]` on the same edge. `key_press`=4'b1001 for one cycle, `key_event`=4'b1001 and `irq`=1.
